bsg_upstream_channel: RTL

Upstream half of the BSG off-chip link. It accepts 32-bit words from the core over a valid/ready handshake and serializes each word into four 8-bit flits on the IO side, least-significant byte first. It transmits only while it holds credits, and the downstream channel returns those credits through single-cycle token pulses. Its IO outputs feed the downstream channel's `io_valid_in`/`io_data_in`, and it consumes that channel's `io_token_out`.

---
 rtl/bsg_upstream_channel.sv | 115 +++++++++++
 1 files changed

// File: rtl/bsg_upstream_channel.sv
// rtl/bsg_upstream_channel.sv - credit-gated 32-bit word to 8-bit flit serializer
module bsg_upstream_channel #(
  parameter int CREDITS = 64,
  parameter int CW      = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_valid_in,
  input  logic [31:0]   core_data_in,
  output logic          core_ready_out,
  output logic          io_valid_out,
  output logic [7:0]    io_data_out,
  input  logic          io_token_in,
  output logic [CW-1:0] credit_cnt,
  output logic          credit_overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  state_t        state, state_n;
  logic [1:0]    beat, beat_n;
  logic [31:0]   hold, hold_n;
  logic          valid_n;
  logic [7:0]    data_n;
  logic [CW-1:0] cnt_n;
  logic          ovf_n;
  logic          spend;
  logic          accept;
  logic [7:0]    cur_byte;

  // A new word fits when idle, or when the last flit of the current word leaves this edge
  assign core_ready_out = (state == IDLE) ||
                          ((state == SEND) && (beat == 2'd3) && (credit_cnt != '0));
  assign accept = core_valid_in && core_ready_out;
  // Spending uses the pre-edge count, so a token arriving at zero credit cannot launch a flit
  assign spend  = (state == SEND) && (credit_cnt != '0);

  // Byte of the held word selected by the beat, least-significant first
  always_comb begin
    cur_byte = hold[7:0];
    case (beat)
      2'd0: cur_byte = hold[7:0];
      2'd1: cur_byte = hold[15:8];
      2'd2: cur_byte = hold[23:16];
      2'd3: cur_byte = hold[31:24];
      default: cur_byte = hold[7:0];
    endcase
  end

  // Next-state, flit output and credit accounting
  always_comb begin
    state_n = state;
    beat_n  = beat;
    hold_n  = hold;
    valid_n = 1'b0;
    data_n  = io_data_out;
    cnt_n   = credit_cnt;
    ovf_n   = credit_overflow;

    if (spend) begin
      valid_n = 1'b1;
      data_n  = cur_byte;
      beat_n  = beat + 2'd1;
      if (beat == 2'd3) begin
        state_n = IDLE;
      end
    end

    // An accept on the last beat overrides the return to IDLE and restarts at beat 0
    if (accept) begin
      hold_n  = core_data_in;
      beat_n  = 2'd0;
      state_n = SEND;
    end

    case ({io_token_in, spend})
      2'b01: cnt_n = credit_cnt - 1'b1;
      2'b10: begin
        if (credit_cnt < CREDIT_MAX) begin
          cnt_n = credit_cnt + 1'b1;
        end else begin
          ovf_n = 1'b1;
        end
      end
      default: cnt_n = credit_cnt;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      beat            <= 2'd0;
      hold            <= 32'h0;
      io_valid_out    <= 1'b0;
      io_data_out     <= 8'h00;
      credit_cnt      <= CREDIT_MAX;
      credit_overflow <= 1'b0;
    end else begin
      state           <= state_n;
      beat            <= beat_n;
      hold            <= hold_n;
      io_valid_out    <= valid_n;
      io_data_out     <= data_n;
      credit_cnt      <= cnt_n;
      credit_overflow <= ovf_n;
    end
  end

endmodule
